fizzbuzz_rx: RTL and testbench

Receive-side companion to the fizz/buzz/fizzbuzz flag generator. The block samples the three flag lines every cycle. It recovers the generator's hidden counter phase, outputs the recovered count once locked, and counts loss-of-lock events. It sits on the consumer end of the flag interface, or in a bench as a live protocol checker.

---
 rtl/fizzbuzz_pkg.sv | 16 +
 rtl/fizzbuzz_ref_gen.sv | 63 ++++++
 rtl/fizzbuzz_rx.sv | 155 +++++++++++++++
 tb/tb_fizzbuzz_rx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fizzbuzz_pkg.sv
// Shared types and width helper for the fizz/buzz flag receiver and its
// expected-flag generator.
package fizzbuzz_pkg;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } rx_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned calc_cw(input int unsigned n);
        return (n <= 2) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/fizzbuzz_ref_gen.sv
// Expected-flag generator: candidate count plus per-divisor phase counters, so
// the fizz/buzz predictions need no modulo hardware.
module fizzbuzz_ref_gen
    import fizzbuzz_pkg::*;
#(
    parameter int unsigned FIZZ       = 3,
    parameter int unsigned BUZZ       = 5,
    parameter int unsigned MAX_CYCLES = 100,
    parameter int unsigned CW         = calc_cw(MAX_CYCLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_advance,
    input  logic          i_load0,
    output logic [CW-1:0] o_exp,
    output logic          o_efizz,
    output logic          o_ebuzz,
    output logic          o_efb
);

    localparam int unsigned FW = calc_cw(FIZZ);
    localparam int unsigned BW = calc_cw(BUZZ);

    localparam logic [CW-1:0] ExpLast = CW'(MAX_CYCLES - 1);
    localparam logic [FW-1:0] FphLast = FW'(FIZZ - 1);
    localparam logic [BW-1:0] BphLast = BW'(BUZZ - 1);

    logic [CW-1:0] r_exp;
    logic [FW-1:0] r_fph;
    logic [BW-1:0] r_bph;
    logic          w_wrap;

    assign w_wrap = (r_exp == ExpLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp <= '0;
            r_fph <= '0;
            r_bph <= '0;
        end else if (i_load0) begin
            // Current sample is count 0, so the next one is 1; divisors are >= 2.
            r_exp <= CW'(1);
            r_fph <= FW'(1);
            r_bph <= BW'(1);
        end else if (i_advance) begin
            if (w_wrap) begin
                r_exp <= '0;
                r_fph <= '0;
                r_bph <= '0;
            end else begin
                r_exp <= r_exp + CW'(1);
                r_fph <= (r_fph == FphLast) ? '0 : r_fph + FW'(1);
                r_bph <= (r_bph == BphLast) ? '0 : r_bph + BW'(1);
            end
        end
    end

    assign o_exp   = r_exp;
    assign o_efizz = (r_fph == '0);
    assign o_ebuzz = (r_bph == '0);
    assign o_efb   = o_efizz & o_ebuzz;

endmodule

// File: rtl/fizzbuzz_rx.sv
// Flag receiver: recovers the generator's counter phase from the sampled
// fizz/buzz/fizzbuzz lines, reports the count once locked and counts lock losses.
module fizzbuzz_rx
    import fizzbuzz_pkg::*;
#(
    parameter int unsigned FIZZ       = 3,
    parameter int unsigned BUZZ       = 5,
    parameter int unsigned MAX_CYCLES = 100,
    parameter int unsigned ERR_W      = 16,
    localparam int unsigned CW        = calc_cw(MAX_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fizz,
    input  logic             buzz,
    input  logic             fizzbuzz,
    output logic             locked,
    output logic [CW-1:0]    count,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned    MCW     = calc_cw(MAX_CYCLES + 1);
    localparam logic [MCW-1:0] LockCnt = MCW'(MAX_CYCLES);
    localparam logic [ERR_W-1:0] ErrMax = '1;

    rx_state_e        r_state;
    rx_state_e        w_state_next;
    logic [MCW-1:0]   r_match_cnt;
    logic [MCW-1:0]   w_match_cnt_next;
    logic [MCW-1:0]   w_cnt_inc;

    logic [CW-1:0]    w_exp;
    logic             w_efizz;
    logic             w_ebuzz;
    logic             w_efb;
    logic             w_match;
    logic             w_advance;
    logic             w_load0;
    logic             w_loss;

    logic             r_locked;
    logic [CW-1:0]    r_count;
    logic             r_mismatch;
    logic [ERR_W-1:0] r_err_cnt;

    fizzbuzz_ref_gen #(
        .FIZZ       (FIZZ),
        .BUZZ       (BUZZ),
        .MAX_CYCLES (MAX_CYCLES),
        .CW         (CW)
    ) u_ref_gen (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_advance),
        .i_load0   (w_load0),
        .o_exp     (w_exp),
        .o_efizz   (w_efizz),
        .o_ebuzz   (w_ebuzz),
        .o_efb     (w_efb)
    );

    // Expected triples are always legal, so an illegal sample can never match.
    assign w_match   = (fizz == w_efizz) && (buzz == w_ebuzz) && (fizzbuzz == w_efb);
    assign w_cnt_inc = r_match_cnt + MCW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StSearch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StSearch: begin
                if (fizzbuzz) begin
                    w_state_next = StVerify;
                end
            end
            StVerify: begin
                if (w_match) begin
                    if (w_cnt_inc == LockCnt) begin
                        w_state_next = StLocked;
                    end
                end else begin
                    w_state_next = fizzbuzz ? StVerify : StSearch;
                end
            end
            StLocked: begin
                if (!w_match) begin
                    w_state_next = fizzbuzz ? StVerify : StSearch;
                end
            end
            default: w_state_next = StSearch;
        endcase
    end

    always_comb begin
        w_advance        = 1'b0;
        w_load0          = 1'b0;
        w_loss           = 1'b0;
        w_match_cnt_next = r_match_cnt;
        unique case (r_state)
            StSearch: begin
                if (fizzbuzz) begin
                    w_load0          = 1'b1;
                    w_match_cnt_next = MCW'(1);
                end
            end
            StVerify, StLocked: begin
                w_loss = (r_state == StLocked) && !w_match;
                if (w_match) begin
                    w_advance = 1'b1;
                    if (r_state == StVerify) begin
                        w_match_cnt_next = w_cnt_inc;
                    end
                end else if (fizzbuzz) begin
                    // A failing sample that carries fizzbuzz restarts the candidate at once.
                    w_load0          = 1'b1;
                    w_match_cnt_next = MCW'(1);
                end else begin
                    w_match_cnt_next = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
            r_count     <= '0;
            r_mismatch  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_match_cnt <= w_match_cnt_next;
            r_locked    <= (w_state_next == StLocked);
            r_count     <= w_load0 ? '0 : w_exp;
            r_mismatch  <= w_loss;
            if (w_loss && (r_err_cnt != ErrMax)) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign locked   = r_locked;
    assign count    = r_count;
    assign mismatch = r_mismatch;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_fizzbuzz_rx.sv
// Scoreboard bench for fizzbuzz_rx: a behavioural generator and receiver model
// predict every cycle's outputs; a monitor compares them against the DUT.
module tb_fizzbuzz_rx;

    localparam int unsigned FIZZ    = 3;
    localparam int unsigned BUZZ    = 5;
    localparam int unsigned MAXC    = 100;
    localparam int unsigned ERR_W   = 2;
    localparam int unsigned CW      = 7;
    localparam int          ERR_MAX = (1 << ERR_W) - 1;

    localparam int MSearch = 0;
    localparam int MVerify = 1;
    localparam int MLocked = 2;

    typedef struct {
        bit locked;
        int count;
        bit mism;
        int err;
    } exp_t;

    exp_t sb_q[$];

    logic             clk = 1'b0;
    logic             reset;
    logic             fizz;
    logic             buzz;
    logic             fizzbuzz;
    logic             locked;
    logic [CW-1:0]    count;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    int gen_cnt;
    bit gen_rst;

    int m_mode;
    int m_exp;
    int m_run;
    int m_err;

    always #5 clk = ~clk;

    fizzbuzz_rx #(
        .FIZZ       (FIZZ),
        .BUZZ       (BUZZ),
        .MAX_CYCLES (MAXC),
        .ERR_W      (ERR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fizz     (fizz),
        .buzz     (buzz),
        .fizzbuzz (fizzbuzz),
        .locked   (locked),
        .count    (count),
        .mismatch (mismatch),
        .err_cnt  (err_cnt)
    );

    function automatic bit [2:0] gen_flags(input int c);
        bit f, b;
        f = (c % FIZZ) == 0;
        b = (c % BUZZ) == 0;
        return {f, b, f & b};
    endfunction

    // Receiver behaviour: one call per sampled edge, pushes the outputs that edge produces.
    task automatic model_step(input bit rst, input bit fz, input bit bz, input bit fb);
        exp_t e;
        bit   ef, eb, hit;
        e.mism = 1'b0;
        if (rst) begin
            m_mode  = MSearch;
            m_exp   = 0;
            m_run   = 0;
            m_err   = 0;
            e.count = 0;
        end else begin
            ef      = (m_exp % FIZZ) == 0;
            eb      = (m_exp % BUZZ) == 0;
            hit     = (fz == ef) && (bz == eb) && (fb == (ef && eb));
            e.count = m_exp;
            if (m_mode == MLocked && !hit) begin
                e.mism = 1'b1;
                if (m_err < ERR_MAX) m_err++;
            end
            if (m_mode == MSearch) begin
                if (fb) begin
                    m_mode = MVerify;
                    m_exp  = 1;
                    m_run  = 1;
                end
            end else if (hit) begin
                m_exp = (m_exp + 1) % MAXC;
                if (m_mode == MVerify) begin
                    m_run++;
                    if (m_run == MAXC) m_mode = MLocked;
                end
            end else if (fb) begin
                m_mode = MVerify;
                m_exp  = 1;
                m_run  = 1;
            end else begin
                m_mode = MSearch;
            end
        end
        e.locked = (m_mode == MLocked);
        e.err    = m_err;
        sb_q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit ovr, input bit [2:0] ovr_flags);
        bit [2:0] fl;
        @(negedge clk);
        if (ovr) fl = ovr_flags;
        else if (gen_rst) fl = 3'b111;
        else fl = gen_flags(gen_cnt);
        reset    = rst;
        fizz     = fl[2];
        buzz     = fl[1];
        fizzbuzz = fl[0];
        model_step(rst, fl[2], fl[1], fl[0]);
        if (!gen_rst) gen_cnt = (gen_cnt + 1) % MAXC;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b000);
    endtask

    task automatic reset_all();
        gen_rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'b000);
        gen_cnt = 0;
    endtask

    task automatic run_to_count(input int c);
        for (int i = 0; i < 2 * MAXC && gen_cnt != c; i++) step(1'b0, 1'b0, 3'b000);
    endtask

    task automatic run_to_mode(input int mode);
        for (int i = 0; i < 4 * MAXC && m_mode != mode; i++) step(1'b0, 1'b0, 3'b000);
    endtask

    task automatic flip_one();
        bit [2:0] m;
        m = 3'b001 << $urandom_range(2);
        step(1'b0, 1'b1, gen_flags(gen_cnt) ^ m);
    endtask

    // Monitor: every edge after a sample was issued yields one checked output set.
    initial begin
        exp_t             e;
        logic [ERR_W-1:0] ee;
        logic [CW-1:0]    ec;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e  = sb_q.pop_front();
                ee = ERR_W'(e.err);
                ec = CW'(e.count);
                vectors++;
                if (locked !== e.locked) begin
                    miscompares++;
                    $display("FAIL locked at %0t: got %b want %b", $time, locked, e.locked);
                end
                if (mismatch !== e.mism) begin
                    miscompares++;
                    $display("FAIL mismatch at %0t: got %b want %b", $time, mismatch, e.mism);
                end
                if (err_cnt !== ee) begin
                    miscompares++;
                    $display("FAIL err_cnt at %0t: got %0d want %0d", $time, err_cnt, ee);
                end
                if (e.locked && count !== ec) begin
                    miscompares++;
                    $display("FAIL count at %0t: got %0d want %0d", $time, count, ec);
                end
            end
        end
    end

    initial begin
        bit [2:0] r;
        reset    = 1'b1;
        fizz     = 1'b0;
        buzz     = 1'b0;
        fizzbuzz = 1'b0;
        gen_cnt  = 0;
        gen_rst  = 1'b0;
        m_mode   = MSearch;
        m_exp    = 0;
        m_run    = 0;
        m_err    = 0;

        // Aligned start, then single fizz drop at 33, then illegal flags at 15.
        reset_all();
        run(250);
        run_to_count(33);
        step(1'b0, 1'b1, gen_flags(33) ^ 3'b100);
        run(250);
        run_to_count(15);
        step(1'b0, 1'b1, 3'b011);
        run(250);

        // Mid-stream start at 40, then a few random phases.
        reset_all();
        gen_cnt = 40;
        run(300);
        repeat (3) begin
            reset_all();
            gen_cnt = $urandom_range(MAXC - 1);
            run(260);
        end

        // Five lock losses saturate the 2-bit error counter, then reset mid-verify.
        repeat (5) begin
            run_to_mode(MLocked);
            run($urandom_range(1, 120));
            flip_one();
        end
        run_to_mode(MVerify);
        run(5);
        step(1'b1, 1'b0, 3'b000);
        run(20);

        // Generator stuck in reset after lock: one loss, then endless reloading.
        reset_all();
        run_to_mode(MLocked);
        run($urandom_range(1, 90));
        gen_rst = 1'b1;
        run(300);
        gen_rst = 1'b0;
        run(250);

        // Random flag noise, including illegal combinations.
        reset_all();
        repeat (300) begin
            r = 3'($urandom());
            step(1'b0, 1'b1, r);
        end
        run(250);

        @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
